// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 memory sequencer
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEF  = 16'hFFFF;
    localparam logic [15:0] WP_LIMIT_DEF = 16'h0030;
    localparam int          SRAM_AW      = 20;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous board inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/slc3_mem_seq.sv
// rtl/slc3_mem_seq.sv - SLC-3 memory-access sequencer (async SRAM + memory-mapped I/O)
// Optional write protection below WP_LIMIT is enabled by defining SLC3_MEM_WPROT_EN.
module slc3_mem_seq
    import slc3_mem_pkg::*;
#(
    parameter int          RD_WAIT  = 2,
    parameter int          WR_WAIT  = 2,
    parameter logic [15:0] IO_ADDR  = IO_ADDR_DEF,
    parameter logic [15:0] WP_LIMIT = WP_LIMIT_DEF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Req,
    input  logic               Wr,
    input  logic [15:0]        Addr,
    input  logic [15:0]        Wdata,
    output logic [15:0]        Rdata,
    output logic               Ack,
    output logic               Busy,
    input  logic [15:0]        Switches,
    output logic [15:0]        Hex_Out,
    output logic               Mem_CE,
    output logic               Mem_UB,
    output logic               Mem_LB,
    output logic               Mem_OE,
    output logic               Mem_WE,
    output logic [SRAM_AW-1:0] Mem_ADDR,
    output logic [15:0]        Mem_Data_Out,
    output logic               Mem_Data_Drive,
`ifdef SLC3_MEM_WPROT_EN
    output logic               Wp_Err,
`endif
    input  logic [15:0]        Mem_Data_In
);

    localparam logic [3:0] RD_CNT0 = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_CNT0 = 4'(WR_WAIT - 1);

    mem_state_t  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] sw_sync;
    logic        accept, is_io;
    logic        wr_blocked;

    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    assign accept = (state == IDLE) && Req;
    assign is_io  = (Addr == IO_ADDR);

`ifdef SLC3_MEM_WPROT_EN
    assign wr_blocked = Wr && !is_io && (Addr < WP_LIMIT);
`else
    assign wr_blocked = 1'b0;
    wire unused_wp_limit = ^WP_LIMIT;
`endif

    sync_2ff #(.WIDTH(16)) u_sw_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .din     (Switches),
        .dout    (sw_sync)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (is_io || wr_blocked) begin
                        state_nxt = DONE;
                    end else if (!Wr) begin
                        state_nxt = RD;
                        cnt_nxt   = RD_CNT0;
                    end else begin
                        state_nxt = WR_SETUP;
                    end
                end
            end
            RD: begin
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = WR_CNT0;
            end
            WR_PULSE: begin
                if (cnt == 4'd0) state_nxt = WR_HOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            WR_HOLD: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change exactly on state boundaries.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            Rdata          <= 16'h0000;
            Hex_Out        <= 16'h0000;
            Mem_ADDR       <= '0;
            Mem_Data_Out   <= 16'h0000;
            Ack            <= 1'b0;
            Busy           <= 1'b0;
            Mem_OE         <= 1'b1;
            Mem_WE         <= 1'b1;
            Mem_Data_Drive <= 1'b0;
`ifdef SLC3_MEM_WPROT_EN
            Wp_Err         <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            Ack            <= (state_nxt == DONE);
            Busy           <= (state_nxt != IDLE);
            Mem_OE         <= (state_nxt != RD);
            Mem_WE         <= (state_nxt != WR_PULSE);
            Mem_Data_Drive <= (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                              (state_nxt == WR_HOLD);

            if (accept) begin
                if (is_io) begin
                    if (Wr) Hex_Out <= Wdata;
                    else    Rdata   <= sw_sync;
                end else if (wr_blocked) begin
`ifdef SLC3_MEM_WPROT_EN
                    Wp_Err <= 1'b1;
`endif
                end else begin
                    Mem_ADDR <= {{(SRAM_AW-16){1'b0}}, Addr};
                    if (Wr) Mem_Data_Out <= Wdata;
                end
            end

            if (state == RD && cnt == 4'd0) Rdata <= Mem_Data_In;
        end
    end

endmodule

// File: doc/slc3_mem_seq.md
Name: slc3_mem_seq

Overview:
- Memory-access sequencer directly downstream of the SLC-3 control unit's memory strobes.
- Turns one-word read/write requests into correctly timed async-SRAM cycles with a programmable number of wait states.
- Decodes the memory-mapped I/O word: switches are read from it; writes go to the hex-display register.
- Returns read data plus a one-cycle Ack, so the control unit's memory states advance on Ack instead of fixed cycle counts.

Parameters:
- RD_WAIT, 2, SRAM cycles with Mem_OE low per read (legal 1..15).
- WR_WAIT, 2, SRAM cycles with Mem_WE low per write (legal 1..15).
- IO_ADDR, 16'hFFFF, memory-mapped I/O word address.
- WP_LIMIT, 16'h0030, first writable address when SLC3_MEM_WPROT_EN is defined.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  access request, level-sensitive, sampled only in IDLE.
- Wr  in  1  1 = write, 0 = read; qualified by Req.
- Addr  in  16  word address.
- Wdata  in  16  write data.
- Rdata  out  16  read data register, valid from the Ack cycle until the next read completes.
- Ack  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except IDLE.
- Switches  in  16  asynchronous board switches.
- Hex_Out  out  16  hex-display register.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
- Mem_ADDR  out  20  SRAM address, zero-extended from the latched Addr.
- Mem_Data_Out  out  16  SRAM write data.
- Mem_Data_Drive  out  1  tri-state enable for the top-level DQ buffer.
- Mem_Data_In  in  16  SRAM read data.

Behaviour:
- Reset (async, Reset_n=0), effective immediately even mid-access:
  - State = IDLE.
  - Rdata, Hex_Out, Mem_ADDR, Mem_Data_Out = 0.
  - Ack, Busy, Mem_Data_Drive = 0.
  - Mem_OE, Mem_WE = 1.
  - An interrupted write must never leave Mem_WE low.
- Mem_CE, Mem_UB and Mem_LB are held at 0 in every state, including reset.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit down-counter cnt times the wait states.
- IDLE, Req=1: latch Addr, Wr and Wdata into internal registers; the inputs may change afterwards.
  - Addr==IO_ADDR goes to DONE in the next cycle with no SRAM strobes.
  - On a read, Rdata <= synchronized Switches.
  - On a write, Hex_Out <= Wdata.
  - Ack therefore appears 1 cycle after the accept edge.
- SRAM read:
  - Path: IDLE → RD, with cnt=RD_WAIT-1 and Mem_OE=0 throughout RD.
  - When cnt==0: Rdata <= Mem_Data_In, then → DONE.
  - Ack appears RD_WAIT+1 cycles after the accept edge.
- SRAM write:
  - WR_SETUP lasts 1 cycle: Mem_ADDR and Mem_Data_Out valid, Mem_Data_Drive=1, Mem_WE=1.
  - WR_PULSE lasts WR_WAIT cycles with Mem_WE=0.
  - WR_HOLD lasts 1 cycle with Mem_WE=1 and data still driven. Then → DONE.
  - Ack appears WR_WAIT+3 cycles after the accept edge.
  - Mem_Data_Drive=1 only in WR_SETUP, WR_PULSE and WR_HOLD.
  - Mem_OE and Mem_WE are never low in the same cycle.
- DONE: Ack=1 for exactly one cycle, then → IDLE. Busy=0 in IDLE only.
- Request handling:
  - Req while Busy=1 is ignored; latched fields are unchanged.
  - Req still high in the IDLE cycle after DONE starts a new access. Back-to-back accesses have exactly one IDLE cycle between them.
- Switches pass through a 2-flop synchronizer, so an I/O read returns the value sampled at least 2 cycles earlier.
- Mem_ADDR holds its last value in IDLE.

Optional Feature:
- SLC3_MEM_WPROT_EN defined:
  - Adds output port Wp_Err (1 bit, reset 0).
  - An SRAM write with latched Addr < WP_LIMIT skips WR_SETUP, WR_PULSE and WR_HOLD and goes IDLE → DONE; Ack appears 1 cycle after accept.
  - Wp_Err is set on such a write and stays set until reset.
  - Reads and I/O writes are unaffected.
- Macro undefined: no Wp_Err port, no write-address comparison, WP_LIMIT is unused.

Decomposition:
- Package slc3_mem_pkg holds:
  - the mem_state_t enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE);
  - the default IO_ADDR and WP_LIMIT constants;
  - the SRAM address width constant (20).
- Sub-module sync_2ff (parameterized width) for the Switches synchronizer; it is reusable for the Run/Continue buttons.
- The FSM, counter and latches stay in one always_ff / always_comb pair inside slc3_mem_seq.

Test Plan:
- Reset: Reset_n low mid-WR_PULSE → same cycle Mem_WE=1, Busy=0, Ack=0, Mem_Data_Drive=0; after release the state is IDLE.
- SRAM read, RD_WAIT=2: Req=1, Wr=0, Addr=16'h1234, model returns 16'hBEEF → Mem_OE=0 for 2 cycles, Mem_ADDR=20'h01234, Ack 3 cycles after accept, Rdata=16'hBEEF.
- SRAM write, WR_WAIT=2: Addr=16'h0040, Wdata=16'hA5A5 → Mem_WE low exactly 2 cycles, data driven one cycle either side, Ack 5 cycles after accept, model holds 16'hA5A5 at 0x0040.
- I/O: Switches=16'h00C3 held 3 cycles, read IO_ADDR → Ack after 1 cycle, Rdata=16'h00C3, no SRAM strobe; write IO_ADDR with Wdata=16'h1F2E → Hex_Out=16'h1F2E.
- Req held high through two reads → exactly two Ack pulses separated by one IDLE cycle; Req pulses during Busy cause no extra access.
- With SLC3_MEM_WPROT_EN: write Addr=16'h0010 → Mem_WE never low, Ack after 1 cycle, Wp_Err=1; a following write to 16'h0030 succeeds and Wp_Err stays 1.
